// File: rtl/stim_ramp_seq.sv
// rtl/stim_ramp_seq.sv - ramp stimulus sequencer: EN1/EN2 burst generator with ROM address walk
module stim_ramp_seq #(
  parameter int AW    = 8,
  parameter int DEPTH = 256,
  parameter int STEPS = 16,
  parameter int DIV_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             STOP,
  input  logic [DIV_W-1:0] step_div,
  input  logic [DIV_W-1:0] hold_len,
  output logic             EN1,
  output logic             EN2,
  output logic [AW-1:0]    rom_addr,
  output logic [4:0]       step_cnt,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RAMP = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_END  = 2'd3;

  localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
  localparam logic [AW-1:0]    ADDR_LAST = AW'(DEPTH - 1);
  localparam logic [AW-1:0]    ADDR_ONE  = AW'(1);
  localparam logic [4:0]       STEPS_C   = 5'(STEPS);

  logic [1:0]       state;
  logic [DIV_W-1:0] div_lat;
  logic [DIV_W-1:0] hold_lat;
  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] hold_cnt;
  logic [DIV_W-1:0] div_nxt;
  logic             pulse_nxt;
  logic [AW-1:0]    addr_inc;

  // div_cnt is the index of the current RAMP cycle within its step; EN2 is
  // registered for the cycle whose index equals the latched divider.
  always_comb begin
    div_nxt   = (div_cnt == div_lat) ? '0 : div_cnt + DIV_ONE;
    pulse_nxt = (div_nxt == div_lat) && (step_cnt < STEPS_C);
    addr_inc  = (rom_addr == ADDR_LAST) ? '0 : rom_addr + ADDR_ONE;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_IDLE;
      div_lat  <= '0;
      hold_lat <= '0;
      div_cnt  <= '0;
      hold_cnt <= '0;
      EN1      <= 1'b0;
      EN2      <= 1'b0;
      rom_addr <= '0;
      step_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          EN1      <= 1'b0;
          EN2      <= 1'b0;
          rom_addr <= '0;
          done     <= 1'b0;
          if (START) begin
            // step_div of 0 would make EN2 continuous; treat it as 1
            div_lat  <= (step_div == '0) ? DIV_ONE : step_div;
            hold_lat <= hold_len;
            div_cnt  <= '0;
            step_cnt <= '0;
            state    <= S_RAMP;
            EN1      <= 1'b1;
            busy     <= 1'b1;
          end
        end
        S_RAMP: begin
          if (STOP) begin
            state    <= S_END;
            EN1      <= 1'b0;
            EN2      <= 1'b0;
            rom_addr <= '0;
            done     <= 1'b0;
          end else if (EN2 && (step_cnt == STEPS_C)) begin
            state    <= S_HOLD;
            hold_cnt <= '0;
            EN2      <= 1'b0;
            rom_addr <= addr_inc;
          end else begin
            div_cnt  <= div_nxt;
            EN2      <= pulse_nxt;
            rom_addr <= addr_inc;
            if (pulse_nxt) begin
              step_cnt <= step_cnt + 5'd1;
            end
          end
        end
        S_HOLD: begin
          EN2 <= 1'b0;
          if (STOP || (hold_cnt == hold_lat)) begin
            state    <= S_END;
            EN1      <= 1'b0;
            rom_addr <= '0;
            done     <= !STOP;
          end else begin
            hold_cnt <= hold_cnt + DIV_ONE;
            rom_addr <= addr_inc;
          end
        end
        default: begin
          state    <= S_IDLE;
          EN1      <= 1'b0;
          EN2      <= 1'b0;
          rom_addr <= '0;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stim_ramp_seq.sv
// tb/tb_stim_ramp_seq.sv - self-checking bench for stim_ramp_seq
module tb_stim_ramp_seq;

  localparam int AW    = 8;
  localparam int DEPTH = 5;
  localparam int STEPS = 16;
  localparam int DIV_W = 8;
  localparam int BOUND = 5000;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             START = 1'b0;
  logic             STOP = 1'b0;
  logic [DIV_W-1:0] step_div = '0;
  logic [DIV_W-1:0] hold_len = '0;
  logic             EN1, EN2, busy, done;
  logic [AW-1:0]    rom_addr;
  logic [4:0]       step_cnt;

  int checks = 0;
  int errors = 0;

  stim_ramp_seq #(.AW(AW), .DEPTH(DEPTH), .STEPS(STEPS), .DIV_W(DIV_W)) dut (
    .CLK(CLK), .RST(RST), .START(START), .STOP(STOP),
    .step_div(step_div), .hold_len(hold_len),
    .EN1(EN1), .EN2(EN2), .rom_addr(rom_addr), .step_cnt(step_cnt),
    .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int sd; int hl; int stop_at; bit noise; bit ss;
    int exp_len; int exp_step; int exp_done;
  } vec_t;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [16:0] outs();
    return {EN1, EN2, rom_addr, step_cnt, busy, done};
  endfunction

  task automatic chk(input string name, input int idx, input logic [16:0] got, input logic [16:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s idx %0d got %h expected %h", name, idx, got, exp);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  // Burst timeline from first principles: STEPS steps of (e+1) cycles, then h+1
  // hold cycles, then one END cycle; a STOP seen in cycle s makes s+1 the END cycle.
  function automatic int end_index(input int e, input int h, input int stop_at);
    int norm_len;
    norm_len = STEPS * (e + 1) + h + 1;
    return (stop_at >= 0 && stop_at < norm_len) ? stop_at + 1 : norm_len;
  endfunction

  function automatic logic [16:0] model(input int e, input int h, input int stop_at, input int j);
    int ramp_len, end_idx, sj, st;
    logic [16:0] v;
    ramp_len = STEPS * (e + 1);
    end_idx  = end_index(e, h, stop_at);
    sj = (j < end_idx) ? j : end_idx - 1;
    st = (sj < ramp_len) ? (sj + 1) / (e + 1) : STEPS;
    v = '0;
    v[6:2] = 5'(st);
    if (j < end_idx) begin
      v[16]   = 1'b1;
      v[15]   = (j < ramp_len) && (((j + 1) % (e + 1)) == 0);
      v[14:7] = 8'(j % DEPTH);
      v[1]    = 1'b1;
    end else if (j == end_idx) begin
      v[1] = 1'b1;
      v[0] = (end_idx == ramp_len + h + 1);
    end
    return v;
  endfunction

  task automatic run_burst(input int sd, input int hl, input int stop_at, input bit noise, input bit ss,
                           output int len, output int stp, output int dn);
    int e, j;
    logic [16:0] endv;
    e = (sd == 0) ? 1 : sd;
    step_div = 8'(sd);
    hold_len = 8'(hl);
    START = 1'b1;
    STOP  = ss;
    tick();
    START = 1'b0;
    STOP  = 1'b0;
    j = 0; dn = 0; stp = 0;
    while (busy && j < BOUND) begin
      chk("cycle", j, outs(), model(e, hl, stop_at, j));
      dn  += int'(done);
      stp = int'(step_cnt);
      if (noise) begin
        step_div = 8'($urandom);
        hold_len = 8'($urandom);
        START    = 1'($urandom);
      end
      STOP = (j == stop_at);
      tick();
      START = 1'b0;
      j++;
    end
    STOP = 1'b0;
    len = j;
    endv = model(e, hl, stop_at, end_index(e, hl, stop_at));
    chk("idle_after", j, outs(), {2'b00, 8'h00, endv[6:2], 2'b00});
  endtask

  vec_t tbl[9];
  int len, stp, dn;

  initial begin
    tbl[0] = '{3, 4, -1, 0, 0, 70, 16, 1};
    tbl[1] = '{0, 0, -1, 0, 0, 34, 16, 1};
    tbl[2] = '{1, 2, -1, 1, 0, 36, 16, 1};
    tbl[3] = '{3, 4, 26, 0, 0, 28,  6, 0};
    tbl[4] = '{0, 9, 34, 1, 0, 36, 16, 0};
    tbl[5] = '{3, 4, 11, 0, 0, 13,  3, 0};
    tbl[6] = '{2, 1, -1, 1, 0, 51, 16, 1};
    tbl[7] = '{5, 0,  0, 0, 0,  2,  0, 0};
    tbl[8] = '{0, 0, -1, 0, 1, 34, 16, 1};

    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    chk("reset", 0, outs(), 17'h0);

    for (int i = 0; i < 9; i++) begin
      run_burst(tbl[i].sd, tbl[i].hl, tbl[i].stop_at, tbl[i].noise, tbl[i].ss, len, stp, dn);
      chk_int($sformatf("len_%0d", i), len, tbl[i].exp_len);
      chk_int($sformatf("step_%0d", i), stp, tbl[i].exp_step);
      chk_int($sformatf("done_%0d", i), dn, tbl[i].exp_done);
    end

    // Reset mid-HOLD, then a full normal burst
    step_div = 8'd0;
    hold_len = 8'd9;
    START = 1'b1;
    tick();
    START = 1'b0;
    repeat (36) tick();
    chk("in_hold", 36, outs(), {1'b1, 1'b0, 8'(36 % DEPTH), 5'd16, 1'b1, 1'b0});
    RST = 1'b1;
    tick();
    chk("rst_hold", 0, outs(), 17'h0);
    RST = 1'b0;
    run_burst(3, 4, -1, 0, 0, len, stp, dn);
    chk_int("len_after_rst", len, 70);
    chk_int("done_after_rst", dn, 1);

    // Reset beats START in the same cycle
    RST = 1'b1;
    START = 1'b1;
    tick();
    RST = 1'b0;
    START = 1'b0;
    chk("rst_start", 0, outs(), 17'h0);
    tick();
    chk("rst_start_idle", 1, outs(), 17'h0);

    for (int r = 0; r < 6; r++) begin
      int sd, hl, sa, e;
      sd = $urandom_range(0, 5);
      hl = $urandom_range(0, 15);
      e  = (sd == 0) ? 1 : sd;
      sa = ($urandom_range(0, 1) == 1) ? $urandom_range(0, STEPS * (e + 1) + hl) : -1;
      run_burst(sd, hl, sa, 1, 1'($urandom), len, stp, dn);
      chk_int($sformatf("rnd_len_%0d", r), len, end_index(e, hl, sa) + 1);
      chk_int($sformatf("rnd_done_%0d", r), dn, (sa < 0) ? 1 : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
